irq_dispatch: RTL and testbench
===============================

// Module: irq_dispatch
// PURPOSE
//  Interrupt dispatch controller: the CPU-side sequencer for the five IF flags
//  (cpu_irqN_trig) driven by the interrupt block. It holds IE (FFFF) and IME.
//  It priority-arbitrates pending interrupts (IE & IF) and sequences the
//  5-M-cycle dispatch: wait, wait, push PCh, push PCl, jump.
//  It returns the one-hot ack that clears the selected IF bit.
//  It generates the HALT wake signal.
// PARAMETERS
//  NIRQ        5       number of interrupt sources; bit 0 = highest priority
//  VEC_BASE    16'h0040 vector of source 0
//  VEC_STRIDE  8       vector spacing; source n vectors to VEC_BASE + n*VEC_STRIDE
// PORTS
//  boga1mhz       in   1     M-cycle clock; all state changes on rising edge
//  reset          in   1     synchronous, active-high reset
//  irq_trig       in   NIRQ  IF flags {joypad,serial,timer,stat,vblank}
//  irq_ack        out  NIRQ  one-hot ack pulse; clears the IF bit
//  ie_wr          in   1     write strobe for the IE register
//  ie_din         in   8     IE write data
//  ie_q           out  8     IE register contents; all 8 bits stored
//  ei, di, reti   in   1     single-cycle decode pulses from the CPU core
//  instr_boundary in   1     CPU is at an opcode-fetch cycle
//  wake           out  1     |(ie_q[NIRQ-1:0] & irq_trig); combinational; IME ignored
//  dispatch       out  1     high in state W1; CPU abandons the fetch, holds PC
//  sp_dec         out  1     CPU decrements SP this cycle
//  push_hi        out  1     CPU writes PC[15:8] to SP
//  push_lo        out  1     CPU writes PC[7:0] to SP
//  pc_load        out  1     CPU loads PC from vector
//  vector         out  16    jump target; valid while pc_load is high
//  ime_q          out  1     current IME
// BEHAVIOUR
//  Reset: state=IDLE, ime=0, ime_dly=0, ie=8'h00, sel=0, vector=16'h0000.
//    All strobe outputs are 0 during and after reset.
//    Reset asserted in any state returns to IDLE on the next edge.
//    A dispatch interrupted by reset is abandoned; no ack is issued afterwards.
//  pend = ie_q[NIRQ-1:0] & irq_trig. Priority is the lowest set bit.
//  FSM: IDLE -> W1 -> W2 -> PUSH_HI -> PUSH_LO -> JUMP -> IDLE.
//    Every state except IDLE lasts exactly one cycle.
//    IDLE->W1 when instr_boundary && ime && |pend (ime here is the registered value).
//    Entering W1 clears ime and ime_dly.
//  Strobes by state:
//    W1:      dispatch=1
//    W2:      sp_dec=1
//    PUSH_HI: push_hi=1, sp_dec=1
//    PUSH_LO: push_lo=1
//    JUMP:    pc_load=1
//  Late arbitration happens in PUSH_LO and uses ie_q and irq_trig at that cycle.
//    An ie_wr during PUSH_HI (a push to FFFF) therefore changes the selection.
//    If pend!=0: sel = lowest set bit; irq_ack[sel] pulses for exactly that cycle;
//      vector = VEC_BASE + sel*VEC_STRIDE is registered for JUMP.
//    If pend==0 (cancelled): no ack; vector = 16'h0000.
//  A flag rising after PUSH_LO is not serviced in this dispatch.
//    It can start a new dispatch at the first instr_boundary after JUMP,
//    provided ime has been re-enabled by then.
//  IME:
//    di clears ime and ime_dly immediately.
//    reti sets ime immediately.
//    ei sets ime_dly; at the next instr_boundary ime <= 1.
//      That boundary dispatch uses the old ime, so one instruction follows EI.
//    Same-cycle conflicts: di beats ei and reti; the W1 entry clear beats ei and reti.
//    ei while ime=1 has no effect.
//  IE:
//    ie_wr has effect in any state; the value is visible on ie_q the next cycle.
//    ie_wr and arbitration in the same cycle: arbitration sees the old value.
//  wake is independent of FSM state and of ime.
//  Inputs are treated as synchronous to boga1mhz.
// TESTING
//  1. Reset, then ie_wr 8'h1F, reti, irq_trig=5'b10100, instr_boundary=1
//     -> W1..JUMP, irq_ack=5'b00100 in PUSH_LO, vector=16'h0050, ime_q=0 after.
//  2. ime=1, ie=8'h01, vblank pending; ie_wr 8'h00 in PUSH_HI
//     -> no ack, vector=16'h0000, pc_load in JUMP.
//  3. ie=8'h04, ime=0, timer set -> wake=1, dispatch never asserted;
//     ei pulse, first boundary no dispatch, second boundary dispatch, vector=16'h0050.
//  4. ei and di in the same cycle -> ime_q stays 0 across 3 boundaries; no dispatch.
//  5. reset asserted in PUSH_HI -> next cycle IDLE, all strobes 0, irq_ack never pulses.
//  6. All five flags set, ie=8'hFF -> five back-to-back dispatches, with reti after
//     each; acks in order 0,1,2,3,4 and vectors 0040/0048/0050/0058/0060.

Source files
------------

// File: rtl/irq_dispatch.sv
// irq_dispatch: holds IE/IME, arbitrates pending interrupts and sequences the 5-M-cycle dispatch.
// Latency: W1 follows the accepting boundary by one edge, JUMP four edges later; no backpressure.
module irq_dispatch #(
   parameter int          NIRQ       = 5,
   parameter logic [15:0] VEC_BASE   = 16'h0040,
   parameter int          VEC_STRIDE = 8
) (
   input  logic            boga1mhz,
   input  logic            reset,
   input  logic [NIRQ-1:0] irq_trig,
   output logic [NIRQ-1:0] irq_ack,
   input  logic            ie_wr,
   input  logic [7:0]      ie_din,
   output logic [7:0]      ie_q,
   input  logic            ei,
   input  logic            di,
   input  logic            reti,
   input  logic            instr_boundary,
   output logic            wake,
   output logic            dispatch,
   output logic            sp_dec,
   output logic            push_hi,
   output logic            push_lo,
   output logic            pc_load,
   output logic [15:0]     vector,
   output logic            ime_q
);

   localparam int SW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      W1      = 3'd1,
      W2      = 3'd2,
      PUSH_HI = 3'd3,
      PUSH_LO = 3'd4,
      JUMP    = 3'd5
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            ime;
   logic            ime_dly;
   logic [NIRQ-1:0] pend;
   logic [SW-1:0]   pick;
   logic            pick_vld;
   logic [SW-1:0]   sel;
   logic            sel_vld;
   logic            enter_w1;

   assign pend     = ie_q[NIRQ-1:0] & irq_trig;
   assign wake     = |pend;
   assign ime_q    = ime;
   assign enter_w1 = (state == IDLE) && instr_boundary && ime && (|pend);

   // Lowest set bit wins: scanning downward leaves the lowest index in pick.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      for (int i = NIRQ-1; i >= 0; i--) begin
         if (pend[i]) begin
            pick     = SW'(i);
            pick_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge boga1mhz) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enter_w1) state_nxt = W1;
         W1:      state_nxt = W2;
         W2:      state_nxt = PUSH_HI;
         PUSH_HI: state_nxt = PUSH_LO;
         PUSH_LO: state_nxt = JUMP;
         JUMP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes are masked while reset is held so an abandoned dispatch emits nothing.
   always_comb begin
      dispatch = 1'b0;
      sp_dec   = 1'b0;
      push_hi  = 1'b0;
      push_lo  = 1'b0;
      pc_load  = 1'b0;
      irq_ack  = '0;
      if (!reset) begin
         case (state)
            W1:      dispatch = 1'b1;
            W2:      sp_dec   = 1'b1;
            PUSH_HI: begin
               push_hi = 1'b1;
               sp_dec  = 1'b1;
            end
            PUSH_LO: begin
               push_lo = 1'b1;
               irq_ack = pick_vld ? (NIRQ'(1) << pick) : '0;
            end
            JUMP:    pc_load  = 1'b1;
            default: ;
         endcase
      end
   end

   // Late arbitration: the selection is frozen in PUSH_LO, after the PC pushes.
   always_ff @(posedge boga1mhz) begin
      if (reset) begin
         sel     <= '0;
         sel_vld <= 1'b0;
      end else if (state == PUSH_LO) begin
         sel     <= pick;
         sel_vld <= pick_vld;
      end
   end

   assign vector = sel_vld ? (VEC_BASE + 16'(sel) * 16'(VEC_STRIDE)) : 16'h0000;

   // di and the dispatch entry clear win over any enable in the same cycle.
   always_ff @(posedge boga1mhz) begin
      if (reset) begin
         ime     <= 1'b0;
         ime_dly <= 1'b0;
      end else if (di || enter_w1) begin
         ime     <= 1'b0;
         ime_dly <= 1'b0;
      end else begin
         if (reti)       ime     <= 1'b1;
         if (ei && !ime) ime_dly <= 1'b1;
         if (instr_boundary && ime_dly) begin
            ime     <= 1'b1;
            ime_dly <= 1'b0;
         end
      end
   end

   always_ff @(posedge boga1mhz) begin
      if (reset)      ie_q <= 8'h00;
      else if (ie_wr) ie_q <= ie_din;
   end

endmodule

// File: tb/tb_irq_dispatch.sv
// Bench for irq_dispatch: table of directed vectors, hand sequences, then random traffic vs a reference model.
module tb_irq_dispatch;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  irq_trig;
   logic [4:0]  irq_ack;
   logic        ie_wr;
   logic [7:0]  ie_din;
   logic [7:0]  ie_q;
   logic        ei, di, reti, instr_boundary;
   logic        wake, dispatch, sp_dec, push_hi, push_lo, pc_load;
   logic [15:0] vector;
   logic        ime_q;
   logic [4:0]  strb;

   int checks   = 0;
   int failures = 0;

   // Reference model: dispatch progress as a step count (0 = idle, 1..5 = the five cycles).
   int          m_step;
   bit          m_ime, m_dly;
   logic [7:0]  m_ie;
   logic [15:0] m_vec;

   always #5 clk = ~clk;

   assign strb = {dispatch, sp_dec, push_hi, push_lo, pc_load};

   irq_dispatch dut (
      .boga1mhz       (clk),
      .reset          (reset),
      .irq_trig       (irq_trig),
      .irq_ack        (irq_ack),
      .ie_wr          (ie_wr),
      .ie_din         (ie_din),
      .ie_q           (ie_q),
      .ei             (ei),
      .di             (di),
      .reti           (reti),
      .instr_boundary (instr_boundary),
      .wake           (wake),
      .dispatch       (dispatch),
      .sp_dec         (sp_dec),
      .push_hi        (push_hi),
      .push_lo        (push_lo),
      .pc_load        (pc_load),
      .vector         (vector),
      .ime_q          (ime_q)
   );

   typedef struct {
      bit         rst;
      logic [4:0] trig;
      bit         wr;
      logic [7:0] din;
      bit         e, d, rt, ib;
      logic [4:0] x_strb;
      logic [4:0] x_ack;
      logic [15:0] x_vec;
      bit         x_ime;
      bit         x_wake;
   } vec_t;

   vec_t tbl [11];

   function automatic int lowest(input logic [4:0] p);
      for (int i = 0; i < 5; i++) if (p[i]) return i;
      return -1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drv(input bit r, input logic [4:0] t, input bit w, input logic [7:0] d,
                      input bit e, input bit dd, input bit rt, input bit ib);
      reset = r; irq_trig = t; ie_wr = w; ie_din = d;
      ei = e; di = dd; reti = rt; instr_boundary = ib;
   endtask

   task automatic model_check();
      logic [4:0] pend;
      logic [4:0] es;
      logic [4:0] ea;
      int lo;
      pend = m_ie[4:0] & irq_trig;
      lo   = lowest(pend);
      es   = 5'b00000;
      if (!reset) begin
         case (m_step)
            1: es = 5'b10000;
            2: es = 5'b01000;
            3: es = 5'b01100;
            4: es = 5'b00010;
            5: es = 5'b00001;
            default: es = 5'b00000;
         endcase
      end
      ea = (!reset && m_step == 4 && lo >= 0) ? 5'(1 << lo) : 5'b00000;
      chk("m_strobes", strb, es);
      chk("m_ack", irq_ack, ea);
      chk("m_wake", wake, |pend);
      chk("m_ime", ime_q, m_ime);
      chk("m_ie", ie_q, m_ie);
      if (es[0]) chk("m_vector", vector, m_vec);
   endtask

   task automatic model_update();
      logic [4:0] pend;
      int lo;
      bit start, old_ime, old_dly;
      pend = m_ie[4:0] & irq_trig;
      lo   = lowest(pend);
      if (reset) begin
         m_step = 0; m_ime = 0; m_dly = 0; m_ie = 8'h00; m_vec = 16'h0000;
      end else begin
         old_ime = m_ime;
         old_dly = m_dly;
         start   = (m_step == 0) && instr_boundary && old_ime && (pend != 0);
         if (m_step == 4) m_vec = (lo >= 0) ? 16'(64 + 8 * lo) : 16'h0000;
         if (di || start) begin
            m_ime = 0; m_dly = 0;
         end else begin
            if (reti) m_ime = 1;
            if (instr_boundary && old_dly) begin
               m_ime = 1; m_dly = 0;
            end else if (ei && !old_ime) begin
               m_dly = 1;
            end
         end
         if (start)                         m_step = 1;
         else if (m_step >= 1 && m_step <= 4) m_step = m_step + 1;
         else                               m_step = 0;
         if (ie_wr) m_ie = ie_din;
      end
   endtask

   task automatic sample();
      #1;
      model_check();
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   // Expects IDLE, ime=1 and something pending; walks the whole dispatch.
   task automatic run_disp(input string tag, input bit wr_hi, input logic [7:0] din_hi,
                           input logic [4:0] eack, input logic [15:0] evec);
      drv(0, irq_trig, 0, 8'h00, 0, 0, 0, 1);
      sample(); chk({tag, "_idle_strb"}, strb, 5'b00000); advance();
      instr_boundary = 1'b0;
      sample(); chk({tag, "_w1"}, strb, 5'b10000); chk({tag, "_w1_ime"}, ime_q, 1'b0); advance();
      sample(); chk({tag, "_w2"}, strb, 5'b01000); advance();
      ie_wr = wr_hi; ie_din = din_hi;
      sample(); chk({tag, "_push_hi"}, strb, 5'b01100); advance();
      ie_wr = 1'b0;
      sample(); chk({tag, "_push_lo"}, strb, 5'b00010); chk({tag, "_ack"}, irq_ack, eack); advance();
      irq_trig = irq_trig & ~eack;
      sample(); chk({tag, "_jump"}, strb, 5'b00001); chk({tag, "_vector"}, vector, evec);
      chk({tag, "_ime_after"}, ime_q, 1'b0); advance();
   endtask

   initial begin
      m_step = 0; m_ime = 0; m_dly = 0; m_ie = 8'h00; m_vec = 16'h0000;

      // rst trig wr din e d rt ib | strobes ack vec ime wake
      tbl[0]  = '{1, 5'b00000, 0, 8'h00, 0, 0, 0, 0, 5'b00000, 5'b00000, 16'h0000, 0, 0};
      tbl[1]  = '{0, 5'b00000, 1, 8'h1F, 0, 0, 0, 0, 5'b00000, 5'b00000, 16'h0000, 0, 0};
      tbl[2]  = '{0, 5'b10100, 0, 8'h00, 0, 0, 1, 0, 5'b00000, 5'b00000, 16'h0000, 0, 1};
      tbl[3]  = '{0, 5'b10100, 0, 8'h00, 0, 0, 0, 1, 5'b00000, 5'b00000, 16'h0000, 1, 1};
      tbl[4]  = '{0, 5'b10100, 0, 8'h00, 0, 0, 0, 0, 5'b10000, 5'b00000, 16'h0000, 0, 1};
      tbl[5]  = '{0, 5'b10100, 0, 8'h00, 0, 0, 0, 0, 5'b01000, 5'b00000, 16'h0000, 0, 1};
      tbl[6]  = '{0, 5'b10100, 0, 8'h00, 0, 0, 0, 0, 5'b01100, 5'b00000, 16'h0000, 0, 1};
      tbl[7]  = '{0, 5'b10100, 0, 8'h00, 0, 0, 0, 0, 5'b00010, 5'b00100, 16'h0000, 0, 1};
      tbl[8]  = '{0, 5'b10100, 0, 8'h00, 0, 0, 0, 0, 5'b00001, 5'b00000, 16'h0050, 0, 1};
      tbl[9]  = '{0, 5'b10100, 0, 8'h00, 0, 0, 0, 1, 5'b00000, 5'b00000, 16'h0000, 0, 1};
      tbl[10] = '{0, 5'b10100, 0, 8'h00, 0, 0, 0, 1, 5'b00000, 5'b00000, 16'h0000, 0, 1};

      drv(1, 5'b00000, 0, 8'h00, 0, 0, 0, 0);
      repeat (2) advance();

      // Directed basic dispatch with timer above vblank-less pending set.
      for (int i = 0; i < 11; i++) begin
         drv(tbl[i].rst, tbl[i].trig, tbl[i].wr, tbl[i].din, tbl[i].e, tbl[i].d, tbl[i].rt, tbl[i].ib);
         sample();
         chk($sformatf("t1_strb[%0d]", i), strb, tbl[i].x_strb);
         chk($sformatf("t1_ack[%0d]", i), irq_ack, tbl[i].x_ack);
         chk($sformatf("t1_ime[%0d]", i), ime_q, tbl[i].x_ime);
         chk($sformatf("t1_wake[%0d]", i), wake, tbl[i].x_wake);
         if (tbl[i].x_strb[0]) chk($sformatf("t1_vec[%0d]", i), vector, tbl[i].x_vec);
         advance();
      end

      // IE cleared by a write during PUSH_HI cancels the dispatch.
      drv(0, 5'b00001, 1, 8'h01, 0, 0, 1, 0);
      sample(); advance();
      run_disp("t2", 1, 8'h00, 5'b00000, 16'h0000);

      // EI delay: wake without dispatch, then one instruction of grace after EI.
      drv(0, 5'b00100, 1, 8'h04, 0, 1, 0, 0);
      sample(); advance();
      for (int i = 0; i < 3; i++) begin
         drv(0, 5'b00100, 0, 8'h00, 0, 0, 0, 1);
         sample(); chk("t3_wake", wake, 1'b1); chk("t3_no_disp", dispatch, 1'b0); advance();
      end
      drv(0, 5'b00100, 0, 8'h00, 1, 0, 0, 0);
      sample(); advance();
      drv(0, 5'b00100, 0, 8'h00, 0, 0, 0, 1);
      sample(); chk("t3_first_bnd_ime", ime_q, 1'b0); advance();
      drv(0, 5'b00100, 0, 8'h00, 0, 0, 0, 0);
      sample(); chk("t3_first_bnd_nodisp", dispatch, 1'b0); chk("t3_ime_set", ime_q, 1'b1); advance();
      run_disp("t3", 0, 8'h00, 5'b00100, 16'h0050);

      // EI and DI together: DI wins.
      drv(0, 5'b00100, 0, 8'h00, 1, 1, 0, 0);
      sample(); advance();
      for (int i = 0; i < 3; i++) begin
         drv(0, 5'b00100, 0, 8'h00, 0, 0, 0, 1);
         sample(); chk("t4_ime", ime_q, 1'b0); chk("t4_no_disp", strb, 5'b00000); advance();
      end
      drv(0, 5'b00100, 0, 8'h00, 0, 0, 0, 0);
      sample(); chk("t4_no_disp_end", strb, 5'b00000); advance();

      // Reset in PUSH_HI abandons the dispatch.
      drv(0, 5'b00100, 0, 8'h00, 0, 0, 1, 0);
      sample(); advance();
      drv(0, 5'b00100, 0, 8'h00, 0, 0, 0, 1);
      sample(); advance();
      drv(0, 5'b00100, 0, 8'h00, 0, 0, 0, 0);
      sample(); chk("t5_w1", strb, 5'b10000); advance();
      sample(); chk("t5_w2", strb, 5'b01000); advance();
      reset = 1'b1;
      sample(); chk("t5_rst_strb", strb, 5'b00000); chk("t5_rst_ack", irq_ack, 5'b00000); advance();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sample(); chk("t5_post_strb", strb, 5'b00000); chk("t5_post_ack", irq_ack, 5'b00000); advance();
      end

      // All five pending: serviced in priority order, RETI between dispatches.
      drv(0, 5'b11111, 1, 8'hFF, 0, 0, 0, 0);
      sample(); advance();
      for (int k = 0; k < 5; k++) begin
         drv(0, irq_trig, 0, 8'h00, 0, 0, 1, 0);
         sample(); advance();
         run_disp($sformatf("t6_%0d", k), 0, 8'h00, 5'(1 << k), 16'(64 + 8 * k));
      end

      // Random traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         drv(($urandom % 128) == 0,
             (($urandom % 4) == 0) ? 5'b00000 : 5'($urandom),
             ($urandom % 6) == 0, 8'($urandom),
             ($urandom % 8) == 0, ($urandom % 20) == 0,
             ($urandom % 6) == 0, ($urandom % 2) == 0);
         sample();
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
